bnn_input_loader: RTL and testbench
===================================

// Module: bnn_input_loader
// PURPOSE
//  Streams the input feature words written over SPI out of MEM48x28 port B into the BNN core.
//  It starts on the START_TICK pulse and reads DEPTH consecutive words from BASE_ADDR onward.
//  Words are delivered on a valid/ready stream with 2-entry buffering, so core backpressure never drops or duplicates data.
//  Sits between the memory port B and the BNN IP; signals completion with a one-cycle oDONE.
// PARAMETERS
//  DEPTH      48  number of words streamed per start
//  AW         6   memory address width
//  DW         28  memory/stream data width
//  BASE_ADDR  0   address of first word read
// PORTS
//  iCLK     in   1   system clock (CLOCK_50); all logic on rising edge
//  iRSTn    in   1   synchronous active-low reset
//  iCLR     in   1   synchronous active-high clear, same effect as reset
//  iSTART   in   1   one-cycle start pulse (START_TICK)
//  oADDR    out  AW  memory port B address
//  oRd_EN   out  1   memory port B read enable
//  iDATA    in   DW  memory port B q; valid exactly 1 cycle after oRd_EN
//  oDATA    out  DW  stream data
//  oVALID   out  1   stream valid
//  iREADY   in   1   stream ready from BNN core
//  oLAST    out  1   high with oVALID on word index DEPTH-1
//  oBUSY    out  1   high whenever FSM not in IDLE
//  oDONE    out  1   one-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset/clear (iRSTn=0 or iCLR=1 at an edge): all outputs 0.
//    FSM=IDLE, buffer emptied, in-flight read discarded, counters 0. Reset/clear wins over every other event.
//  - FSM: IDLE -(iSTART)-> RUN -(DEPTH reads issued)-> DRAIN -(last handshake)-> DONE -> IDLE.
//    DONE lasts exactly 1 cycle, with oDONE=1.
//  - iSTART is ignored outside IDLE.
//  - Handshake: a word transfers on an edge where oVALID & iREADY.
//    oDATA/oLAST stay stable while oVALID=1 and iREADY=0.
//  - Buffer: 2-entry FIFO, occupancy occ.
//    - inflight=1 in the cycle after oRd_EN; iDATA is written into the FIFO at that edge.
//  - Read issue (RUN only): oRd_EN=1 iff issued<DEPTH and occ+inflight-pop<2, where pop=oVALID&iREADY.
//    - oADDR=BASE_ADDR+issued. issued increments per read, so the address never wraps within a stream.
//    - oADDR holds its last value when oRd_EN=0.
//  - Timing, with iSTART high in cycle 0 and iREADY held 1:
//    - cycle 1: oRd_EN=1, oADDR=BASE.
//    - cycle 2: iDATA valid.
//    - cycle 3: oVALID=1 with word 0.
//    - Steady state: 1 word/cycle.
//  - oLAST is derived from a sent-word counter (0..DEPTH-1), not from the address.
//  - After the final handshake the next cycle is DONE (oDONE=1, oVALID=0), then IDLE.
//  - oBUSY=1 in RUN, DRAIN and DONE.
//  - A new iSTART in the cycle after DONE is accepted normally.
// TESTING
//  1 iREADY=1, RAM[i]=i+0x100, iSTART cycle 0 -> oADDR 0..47 on cycles 1..48; oDATA 0x100..0x12F on cycles 3..50; oLAST cycle 50; oDONE cycle 51 only.
//  2 iREADY=0 for cycles 10-14 -> at most 2 reads outstanding; no oRd_EN while full; stream resumes with no lost or duplicate words; oDATA stable while stalled.
//  3 iSTART pulsed again at cycle 20 while busy -> ignored; exactly 48 words and one oDONE.
//  4 iCLR=1 at cycle 25 mid-stream -> all outputs 0 next cycle; new iSTART restarts from BASE_ADDR with word 0.
//  5 random iREADY (50%) over 3 back-to-back starts -> scoreboard matches the RAM model; oLAST once per run; oDONE count=3.
//  6 iRSTn=0 with iREADY=0 and buffer full -> all outputs 0 and FSM IDLE after the edge.

Source files
------------

// File: rtl/bnn_input_loader.sv
// Streams DEPTH words from memory port B into the BNN core over a valid/ready stream.
// A 2-entry FIFO absorbs the one-cycle read latency so core backpressure never loses or duplicates words.
module bnn_input_loader #(
    parameter int DEPTH     = 48,
    parameter int AW        = 6,
    parameter int DW        = 28,
    parameter int BASE_ADDR = 0
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iSTART,
    output logic [AW-1:0] oADDR,
    output logic          oRd_EN,
    input  logic [DW-1:0] iDATA,
    output logic [DW-1:0] oDATA,
    output logic          oVALID,
    input  logic          iREADY,
    output logic          oLAST,
    output logic          oBUSY,
    output logic          oDONE
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] sent_q, sent_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          inflight_q;
    logic [DW-1:0] fifo_mem [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    occ_q, occ_d;

    logic          rst;
    logic          valid;
    logic          pop;
    logic          push;
    logic          rd_en;
    logic          last_word;
    logic [2:0]    fill;
    logic [AW-1:0] rd_addr;

    assign rst       = !iRSTn || iCLR;
    assign valid     = (occ_q != 2'd0);
    assign pop       = valid && iREADY;
    assign push      = inflight_q;
    // Slots that will be taken once the in-flight read lands, after this cycle's pop.
    assign fill      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en     = (state_q == S_RUN) && (issued_q < CW'(DEPTH)) && (fill < 3'd2);
    assign last_word = (sent_q == CW'(DEPTH - 1));
    assign rd_addr   = AW'(BASE_ADDR) + AW'(issued_q);

    assign oADDR  = rd_en ? rd_addr : addr_q;
    assign oRd_EN = rd_en;
    assign oDATA  = valid ? fifo_mem[rd_ptr_q] : '0;
    assign oVALID = valid;
    assign oLAST  = valid && last_word;
    assign oBUSY  = (state_q != S_IDLE);
    assign oDONE  = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        sent_d   = sent_q;
        addr_d   = addr_q;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        if (pop) begin
            sent_d = sent_q + CW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_d  = S_RUN;
                    issued_d = '0;
                    sent_d   = '0;
                end
            end
            S_RUN: begin
                if (rd_en) begin
                    issued_d = issued_q + CW'(1);
                    addr_d   = rd_addr;
                    if (issued_q == CW'(DEPTH - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (rst) begin
            state_q    <= S_IDLE;
            issued_q   <= '0;
            sent_q     <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            sent_q     <= sent_d;
            addr_q     <= addr_d;
            inflight_q <= rd_en;
            occ_q      <= occ_d;
            if (push) begin
                wr_ptr_q <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge iCLK) begin
        if (push && !rst) begin
            fifo_mem[wr_ptr_q] <= iDATA;
        end
    end

endmodule

// File: tb/tb_bnn_input_loader.sv
// Directed bench for bnn_input_loader: a stream-level reference model checks every cycle,
// and each scenario adds a few literal expectations at fixed cycles.
module tb_bnn_input_loader;

    localparam int DEPTH = 48;
    localparam int AW    = 6;
    localparam int DW    = 28;

    logic          clk = 1'b0;
    logic          iRSTn = 1'b0;
    logic          iCLR = 1'b0;
    logic          iSTART = 1'b0;
    logic [AW-1:0] oADDR;
    logic          oRd_EN;
    logic [DW-1:0] iDATA = '0;
    logic [DW-1:0] oDATA;
    logic          oVALID;
    logic          iREADY = 1'b1;
    logic          oLAST;
    logic          oBUSY;
    logic          oDONE;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] ram [64];

    bnn_input_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .BASE_ADDR(0)) dut (
        .iCLK(clk), .iRSTn(iRSTn), .iCLR(iCLR), .iSTART(iSTART),
        .oADDR(oADDR), .oRd_EN(oRd_EN), .iDATA(iDATA),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY),
        .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = DW'(i + 'h100);
    end

    // Memory port B: data appears one cycle after a read; garbage otherwise.
    always @(posedge clk) begin
        if (oRd_EN) iDATA <= ram[oADDR];
        else        iDATA <= 28'hBADBEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a stream must look like, judged once per cycle.
    bit            busy_m = 0;
    bit            done_now = 0;
    bit            after_rst = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    int            issued = 0;
    int            sent = 0;
    int            dones = 0;
    int            lasts = 0;

    always @(negedge clk) begin
        bit hs;
        bit start_ok;
        hs = oVALID && iREADY;
        if (after_rst) begin
            chk("rst_data", 64'(oDATA), 64'd0);
            chk("rst_ctl", 64'({oADDR, oRd_EN, oVALID, oLAST, oBUSY, oDONE}), 64'd0);
        end else begin
            chk("busy", 64'(oBUSY), 64'(busy_m));
            chk("done", 64'(oDONE), 64'(done_now));
            if (done_now) chk("done_novalid", 64'(oVALID), 64'd0);
            if (oRd_EN) begin
                chk("rd_addr", 64'(oADDR), 64'(issued));
                chk("rd_count", 64'(issued < DEPTH), 64'd1);
                chk("outstanding", 64'((issued - sent - int'(hs)) < 2), 64'd1);
            end
            if (oVALID) begin
                chk("extra_word", 64'(sent < DEPTH), 64'd1);
                chk("data", 64'(oDATA), 64'(ram[sent % 64]));
                chk("last", 64'(oLAST), 64'(sent == DEPTH - 1));
            end else begin
                chk("last_novalid", 64'(oLAST), 64'd0);
            end
            if (prev_stall) begin
                chk("stall_valid", 64'(oVALID), 64'd1);
                chk("stall_data", 64'(oDATA), 64'(prev_data));
            end
        end
        // Advance to the state the coming edge will produce.
        if (!iRSTn || iCLR) begin
            busy_m = 0; done_now = 0; issued = 0; sent = 0; prev_stall = 0;
            after_rst = 1;
        end else begin
            after_rst = 0;
            start_ok = iSTART && !busy_m;
            if (done_now) begin
                done_now = 0;
                busy_m = 0;
                dones++;
            end
            if (hs) begin
                if (sent == DEPTH - 1) begin
                    done_now = 1;
                    lasts++;
                end
                sent++;
            end
            if (oRd_EN) issued++;
            if (start_ok) begin
                busy_m = 1; issued = 0; sent = 0;
            end
            prev_stall = oVALID && !iREADY;
            prev_data = oDATA;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit rnd);
        bit got;
        got = 0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge clk);
            if (oDONE) got = 1;
            tick();
            if (rnd) iREADY = 1'($urandom_range(0, 1));
        end
        chk("done_seen", 64'(got), 64'd1);
    endtask

    initial begin
        int d0, l0;
        tick(); tick();
        @(negedge clk);
        chk("reset_busy", 64'(oBUSY), 64'd0);
        chk("reset_valid", 64'({oVALID, oRd_EN, oDONE}), 64'd0);
        tick();
        iRSTn = 1'b1;
        tick();

        // 1: full-rate stream, literal cycle positions
        d0 = dones; l0 = lasts;
        pulse_start();
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            if (c == 1)  chk("t1_first_rd", 64'({oRd_EN, oADDR}), 64'({1'b1, 6'd0}));
            if (c == 2)  chk("t1_no_valid", 64'(oVALID), 64'd0);
            if (c == 3)  chk("t1_first_word", 64'({oVALID, oDATA}), 64'({1'b1, 28'h100}));
            if (c == 48) chk("t1_last_rd", 64'({oRd_EN, oADDR}), 64'({1'b1, 6'd47}));
            if (c == 49) chk("t1_rd_stop", 64'(oRd_EN), 64'd0);
            if (c == 50) chk("t1_last_word", 64'({oLAST, oDATA}), 64'({1'b1, 28'h12F}));
            if (c == 51) chk("t1_done", 64'({oDONE, oVALID}), 64'({1'b1, 1'b0}));
            if (c == 52) chk("t1_idle", 64'({oDONE, oBUSY}), 64'd0);
            tick();
        end
        chk("t1_dones", 64'(dones - d0), 64'd1);
        chk("t1_lasts", 64'(lasts - l0), 64'd1);
        tick();

        // 2: backpressure cycles 10-14
        d0 = dones;
        pulse_start();
        for (int c = 1; c <= 15; c++) begin
            iREADY = (c >= 10 && c <= 14) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (c == 14) chk("t2_full", 64'({oVALID, oRd_EN}), 64'({1'b1, 1'b0}));
            tick();
        end
        iREADY = 1'b1;
        wait_done(100, 0);
        chk("t2_dones", 64'(dones - d0), 64'd1);
        chk("t2_words", 64'(sent), 64'(DEPTH));

        // 3: second start while busy is ignored
        d0 = dones; l0 = lasts;
        pulse_start();
        for (int c = 1; c < 20; c++) tick();
        pulse_start();
        wait_done(100, 0);
        tick(); tick();
        chk("t3_dones", 64'(dones - d0), 64'd1);
        chk("t3_lasts", 64'(lasts - l0), 64'd1);
        chk("t3_words", 64'(sent), 64'(DEPTH));

        // 4: clear mid-stream, then restart from word 0
        pulse_start();
        for (int c = 1; c < 25; c++) tick();
        iCLR = 1'b1;
        tick();
        iCLR = 1'b0;
        @(negedge clk);
        chk("t4_cleared", 64'({oBUSY, oVALID, oRd_EN, oDATA}), 64'd0);
        tick();
        d0 = dones;
        pulse_start();
        tick(); tick();
        @(negedge clk);
        chk("t4_restart_word", 64'({oVALID, oDATA}), 64'({1'b1, 28'h100}));
        wait_done(100, 0);
        chk("t4_dones", 64'(dones - d0), 64'd1);

        // 5: random ready over three back-to-back runs
        d0 = dones; l0 = lasts;
        for (int r = 0; r < 3; r++) begin
            pulse_start();
            wait_done(400, 1);
        end
        iREADY = 1'b1;
        tick(); tick();
        chk("t5_dones", 64'(dones - d0), 64'd3);
        chk("t5_lasts", 64'(lasts - l0), 64'd3);

        // 6: reset while stalled with a full buffer
        iREADY = 1'b0;
        pulse_start();
        for (int c = 1; c < 8; c++) tick();
        @(negedge clk);
        chk("t6_full", 64'({oVALID, oRd_EN, oBUSY}), 64'({1'b1, 1'b0, 1'b1}));
        iRSTn = 1'b0;
        tick();
        iRSTn = 1'b1;
        @(negedge clk);
        chk("t6_reset", 64'({oBUSY, oVALID, oRd_EN, oLAST, oDONE, oDATA}), 64'd0);
        iREADY = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        chk("t6_stays_idle", 64'({oBUSY, oVALID}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
